sd_sec_arbiter: RTL and testbench

- Two-client arbiter in front of the SD sector read/write engine (sd_card_sec_read_write), which exposes a single sector port.
- Ports A and B (e.g. a file loader and a frame/log writer) each request 512-byte sector reads or writes.
- The arbiter grants one client at a time (round-robin by default), drives the engine's read/write strobe and address, and routes byte-level data, strobes and completion to the owning client only.

---
 rtl/sd_sec_arbiter_if.sv | 50 +++++
 rtl/sd_sec_arbiter.sv | 124 ++++++++++++
 tb/tb_sd_sec_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sec_arbiter_if.sv
// Bundle of client, status and engine-side signals around sd_sec_arbiter.
// slave = arbiter side; master = clients plus the engine.
interface sd_sec_arbiter_if #(
  parameter int SEC_BYTES = 512
);
  localparam int IDX_W = $clog2(SEC_BYTES + 1);

  logic             sd_init_done;
  logic             a_req, b_req;
  logic             a_wr, b_wr;
  logic [31:0]      a_addr, b_addr;
  logic             a_gnt, b_gnt;
  logic [7:0]       a_rd_data, b_rd_data;
  logic             a_rd_valid, b_rd_valid;
  logic [7:0]       a_wr_data, b_wr_data;
  logic             a_wr_req, b_wr_req;
  logic             a_done, b_done;
  logic [IDX_W-1:0] byte_idx;
  logic             busy;
  logic             sd_sec_read;
  logic [31:0]      sd_sec_read_addr;
  logic [7:0]       sd_sec_read_data;
  logic             sd_sec_read_data_valid;
  logic             sd_sec_read_end;
  logic             sd_sec_write;
  logic [31:0]      sd_sec_write_addr;
  logic [7:0]       sd_sec_write_data;
  logic             sd_sec_write_data_req;
  logic             sd_sec_write_end;

  modport slave (
    input  sd_init_done, a_req, b_req, a_wr, b_wr, a_addr, b_addr,
           a_wr_data, b_wr_data, sd_sec_read_data, sd_sec_read_data_valid,
           sd_sec_read_end, sd_sec_write_data_req, sd_sec_write_end,
    output a_gnt, b_gnt, a_rd_data, b_rd_data, a_rd_valid, b_rd_valid,
           a_wr_req, b_wr_req, a_done, b_done, byte_idx, busy,
           sd_sec_read, sd_sec_read_addr, sd_sec_write, sd_sec_write_addr,
           sd_sec_write_data
  );

  modport master (
    output sd_init_done, a_req, b_req, a_wr, b_wr, a_addr, b_addr,
           a_wr_data, b_wr_data, sd_sec_read_data, sd_sec_read_data_valid,
           sd_sec_read_end, sd_sec_write_data_req, sd_sec_write_end,
    input  a_gnt, b_gnt, a_rd_data, b_rd_data, a_rd_valid, b_rd_valid,
           a_wr_req, b_wr_req, a_done, b_done, byte_idx, busy,
           sd_sec_read, sd_sec_read_addr, sd_sec_write, sd_sec_write_addr,
           sd_sec_write_data
  );
endinterface

// File: rtl/sd_sec_arbiter.sv
// Two-client arbiter in front of a single-port SD sector engine.
// Round-robin by default; define SD_ARB_FIXED_PRIO_EN to give A fixed priority.
module sd_sec_arbiter #(
  parameter int SEC_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst,
  sd_sec_arbiter_if.slave   bus
);
  localparam int IDX_W = $clog2(SEC_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SEC_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             own_q, own_d;     // 0 = A, 1 = B
  logic             last_q, last_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic             gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic             rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic pick_b, issue, step, end_hit;

`ifdef SD_ARB_FIXED_PRIO_EN
  assign pick_b = !bus.a_req;
`else
  assign pick_b = !bus.a_req || (bus.b_req && !last_q);
`endif

  assign issue   = (state_q == S_ISSUE);
  assign step    = issue && (wr_q ? bus.sd_sec_write_data_req : bus.sd_sec_read_data_valid);
  assign end_hit = wr_q ? bus.sd_sec_write_end : bus.sd_sec_read_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    rd_stb_d = rd_stb_q;
    wr_stb_d = wr_stb_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: if (bus.sd_init_done) state_d = S_ARB;
      S_ARB: begin
        if (!bus.sd_init_done) begin
          state_d = S_IDLE;
        end else if (bus.a_req || bus.b_req) begin
          own_d    = pick_b;
          wr_d     = pick_b ? bus.b_wr   : bus.a_wr;
          addr_d   = pick_b ? bus.b_addr : bus.a_addr;
          gnt_a_d  = !pick_b;
          gnt_b_d  = pick_b;
          rd_stb_d = !wr_d;
          wr_stb_d = wr_d;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (step && idx_q != IDX_MAX) idx_d = idx_q + 1'b1;
        // Drop the strobe on the end edge so the engine cannot re-trigger.
        if (end_hit) begin
          rd_stb_d = 1'b0;
          wr_stb_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = own_q;
        idx_d   = '0;
        state_d = S_ARB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.a_gnt             = gnt_a_q;
  assign bus.b_gnt             = gnt_b_q;
  assign bus.sd_sec_read       = rd_stb_q;
  assign bus.sd_sec_write      = wr_stb_q;
  assign bus.sd_sec_read_addr  = addr_q;
  assign bus.sd_sec_write_addr = addr_q;
  assign bus.sd_sec_write_data = own_q ? bus.b_wr_data : bus.a_wr_data;
  assign bus.a_rd_data         = bus.sd_sec_read_data;
  assign bus.b_rd_data         = bus.sd_sec_read_data;
  assign bus.a_rd_valid        = issue && bus.sd_sec_read_data_valid && !own_q;
  assign bus.b_rd_valid        = issue && bus.sd_sec_read_data_valid &&  own_q;
  assign bus.a_wr_req          = issue && bus.sd_sec_write_data_req && !own_q;
  assign bus.b_wr_req          = issue && bus.sd_sec_write_data_req &&  own_q;
  assign bus.a_done            = (state_q == S_DONE) && !own_q;
  assign bus.b_done            = (state_q == S_DONE) &&  own_q;
  assign bus.byte_idx          = idx_q;
  assign bus.busy              = issue || (state_q == S_DONE);
endmodule

// File: tb/tb_sd_sec_arbiter.sv
// Directed bench for sd_sec_arbiter: transaction-level reference model checked
// every cycle, plus literal checks on latency, counts and grant order.
module tb_sd_sec_arbiter;
  localparam int SB = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_sec_arbiter_if #(.SEC_BYTES(SB)) bus ();
  sd_sec_arbiter #(.SEC_BYTES(SB)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Client B writes its own byte position as data.
  assign bus.b_wr_data = bus.byte_idx[7:0];

  int total = 0;
  int bad   = 0;
  int cnt_arv, cnt_brv, cnt_awr, cnt_bwr, cnt_gnt, cnt_stb;

  // Reference model: one in-flight transaction plus arbitration history.
  typedef enum int {M_OFF, M_PICK, M_XFER, M_FIN} mph_t;
  mph_t        m_ph;
  logic        m_own, m_last, m_wr, m_ga, m_gb;
  logic [31:0] m_addr;
  int          m_cnt;
  logic        m_w;

  function automatic logic winner_is_b(logic a, logic b, logic last_b);
`ifdef SD_ARB_FIXED_PRIO_EN
    return !a;
`else
    // Contention goes to whoever did not own the previous sector.
    return !a || (b && !last_b);
`endif
  endfunction

  assign m_w = winner_is_b(bus.a_req, bus.b_req, m_last);

  always @(posedge clk) begin
    m_ga <= 1'b0;
    m_gb <= 1'b0;
    if (rst) begin
      m_ph <= M_OFF; m_last <= 1'b1; m_own <= 1'b0; m_wr <= 1'b0;
      m_addr <= '0; m_cnt <= 0;
    end else begin
      case (m_ph)
        M_OFF:  if (bus.sd_init_done) m_ph <= M_PICK;
        M_PICK: begin
          if (!bus.sd_init_done) m_ph <= M_OFF;
          else if (bus.a_req || bus.b_req) begin
            m_own  <= m_w;
            m_wr   <= m_w ? bus.b_wr : bus.a_wr;
            m_addr <= m_w ? bus.b_addr : bus.a_addr;
            m_ga   <= !m_w;
            m_gb   <= m_w;
            m_ph   <= M_XFER;
          end
        end
        M_XFER: begin
          if ((m_wr ? bus.sd_sec_write_data_req : bus.sd_sec_read_data_valid) && m_cnt < SB)
            m_cnt <= m_cnt + 1;
          if (m_wr ? bus.sd_sec_write_end : bus.sd_sec_read_end) m_ph <= M_FIN;
        end
        default: begin
          m_last <= m_own;
          m_cnt  <= 0;
          m_ph   <= M_PICK;
        end
      endcase
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic xfer, fin;
    xfer = (m_ph == M_XFER);
    fin  = (m_ph == M_FIN);
    chk("a_gnt", 32'(bus.a_gnt), 32'(m_ga));
    chk("b_gnt", 32'(bus.b_gnt), 32'(m_gb));
    chk("sd_sec_read", 32'(bus.sd_sec_read), 32'(xfer && !m_wr));
    chk("sd_sec_write", 32'(bus.sd_sec_write), 32'(xfer && m_wr));
    chk("rd_addr", bus.sd_sec_read_addr, m_addr);
    chk("wr_addr", bus.sd_sec_write_addr, m_addr);
    chk("busy", 32'(bus.busy), 32'(xfer || fin));
    chk("a_done", 32'(bus.a_done), 32'(fin && !m_own));
    chk("b_done", 32'(bus.b_done), 32'(fin && m_own));
    chk("byte_idx", 32'(bus.byte_idx), 32'(m_cnt));
    chk("a_rd_valid", 32'(bus.a_rd_valid), 32'(xfer && bus.sd_sec_read_data_valid && !m_own));
    chk("b_rd_valid", 32'(bus.b_rd_valid), 32'(xfer && bus.sd_sec_read_data_valid && m_own));
    chk("a_wr_req", 32'(bus.a_wr_req), 32'(xfer && bus.sd_sec_write_data_req && !m_own));
    chk("b_wr_req", 32'(bus.b_wr_req), 32'(xfer && bus.sd_sec_write_data_req && m_own));
    chk("a_rd_data", 32'(bus.a_rd_data), 32'(bus.sd_sec_read_data));
    chk("b_rd_data", 32'(bus.b_rd_data), 32'(bus.sd_sec_read_data));
    if (xfer)
      chk("wr_data", 32'(bus.sd_sec_write_data), 32'(m_own ? bus.b_wr_data : bus.a_wr_data));
    cnt_arv += int'(bus.a_rd_valid);
    cnt_brv += int'(bus.b_rd_valid);
    cnt_awr += int'(bus.a_wr_req);
    cnt_bwr += int'(bus.b_wr_req);
    cnt_gnt += int'(bus.a_gnt || bus.b_gnt);
    cnt_stb += int'(bus.sd_sec_read || bus.sd_sec_write);
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
  endtask

  task automatic clr_cnt();
    cnt_arv = 0; cnt_brv = 0; cnt_awr = 0; cnt_bwr = 0; cnt_gnt = 0; cnt_stb = 0;
  endtask

  task automatic wait_gnt(string nm, output logic who_b);
    logic got;
    got = 1'b0;
    who_b = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      cyc();
      if (bus.a_gnt || bus.b_gnt) begin
        got = 1'b1;
        who_b = bus.b_gnt;
      end
    end
    if (!got) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic pulse_read_end();
    bus.sd_sec_read_end = 1'b1; cyc();
    bus.sd_sec_read_end = 1'b0;
  endtask

  logic       who;
  logic [3:0] seq;
  logic [3:0] exp_seq;
  int         lat;

  initial begin
    bus.sd_init_done = 0; bus.a_req = 0; bus.b_req = 0; bus.a_wr = 0; bus.b_wr = 0;
    bus.a_addr = '0; bus.b_addr = '0; bus.a_wr_data = 8'hEE;
    bus.sd_sec_read_data = '0; bus.sd_sec_read_data_valid = 0; bus.sd_sec_read_end = 0;
    bus.sd_sec_write_data_req = 0; bus.sd_sec_write_end = 0;
    clr_cnt();

    // Reset state
    repeat (3) cyc();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_idx", 32'(bus.byte_idx), 32'd0);
    chk("rst_strobes", 32'({bus.sd_sec_read, bus.sd_sec_write}), 32'd0);
    rst = 0;
    cyc(); cyc();

    // Single A read with a stray write end mid-sector
    bus.sd_init_done = 1; cyc();
    bus.a_req = 1; bus.a_wr = 0; bus.a_addr = 32'h10; cyc();
    chk("s1_gnt_lat", 32'(bus.a_gnt), 32'd1);
    chk("s1_rd_stb", 32'(bus.sd_sec_read), 32'd1);
    chk("s1_rd_addr", bus.sd_sec_read_addr, 32'h10);
    bus.a_req = 0;
    clr_cnt();
    for (int i = 0; i < SB; i++) begin
      bus.sd_sec_read_data_valid = 1; bus.sd_sec_read_data = 8'(i) ^ 8'h5A; cyc();
      if (i % 100 == 50) begin bus.sd_sec_read_data_valid = 0; cyc(); end
    end
    bus.sd_sec_read_data_valid = 0; cyc();
    chk("s1_idx", 32'(bus.byte_idx), 32'd512);
    chk("s1_a_rv", 32'(cnt_arv), 32'd512);
    chk("s1_b_rv", 32'(cnt_brv), 32'd0);
    bus.sd_sec_write_end = 1; cyc();
    bus.sd_sec_write_end = 0; cyc();
    chk("s6_stray_busy", 32'(bus.busy), 32'd1);
    chk("s6_stray_done", 32'(bus.a_done), 32'd0);
    chk("s6_stray_stb", 32'(bus.sd_sec_read), 32'd1);
    pulse_read_end();
    chk("s1_done", 32'(bus.a_done), 32'd1);
    chk("s1_stb_low", 32'(bus.sd_sec_read), 32'd0);
    cyc();
    chk("s1_done_pulse", 32'(bus.a_done), 32'd0);
    chk("s1_idx_clr", 32'(bus.byte_idx), 32'd0);

    // Contention from reset: four sectors
    rst = 1; bus.sd_init_done = 0; cyc();
    rst = 0; cyc();
    bus.sd_init_done = 1;
    bus.a_req = 1; bus.b_req = 1; bus.a_addr = 32'hA0; bus.b_addr = 32'hB0;
    seq = '0;
    for (int s = 0; s < 4; s++) begin
      wait_gnt("s2_gnt_timeout", who);
      seq[s] = who;
      for (int i = 0; i < 3; i++) begin
        bus.sd_sec_read_data_valid = 1; bus.sd_sec_read_data = 8'(s * 16 + i); cyc();
      end
      bus.sd_sec_read_data_valid = 0;
      pulse_read_end();
    end
    bus.a_req = 0; bus.b_req = 0;
`ifdef SD_ARB_FIXED_PRIO_EN
    exp_seq = 4'b0000;
`else
    exp_seq = 4'b1010;
`endif
    chk("s2_grant_order", 32'(seq), 32'(exp_seq));
    cyc(); cyc();

    // B write of a full sector, A idle with distinct data
    bus.b_req = 1; bus.b_wr = 1; bus.b_addr = 32'h200;
    wait_gnt("s3_gnt_timeout", who);
    chk("s3_owner_b", 32'(who), 32'd1);
    bus.b_req = 0; bus.b_addr = 32'hDEAD; bus.b_wr = 0;
    chk("s3_wr_stb", 32'(bus.sd_sec_write), 32'd1);
    chk("s3_wr_addr", bus.sd_sec_write_addr, 32'h200);
    clr_cnt();
    for (int i = 0; i < SB; i++) begin
      bus.sd_sec_write_data_req = 1; cyc();
      bus.sd_sec_write_data_req = 0; cyc();
    end
    chk("s3_b_wr", 32'(cnt_bwr), 32'd512);
    chk("s3_a_wr", 32'(cnt_awr), 32'd0);
    chk("s3_idx", 32'(bus.byte_idx), 32'd512);
    chk("s3_addr_held", bus.sd_sec_write_addr, 32'h200);
    bus.sd_sec_write_end = 1; cyc();
    bus.sd_sec_write_end = 0;
    chk("s3_done", 32'(bus.b_done), 32'd1);
    chk("s3_stb_low", 32'(bus.sd_sec_write), 32'd0);
    cyc();

    // Requests held while the engine is not initialised
    bus.sd_init_done = 0; cyc();
    bus.a_req = 1; bus.a_wr = 0; bus.a_addr = 32'h77;
    clr_cnt();
    repeat (100) cyc();
    chk("s4_no_gnt", 32'(cnt_gnt), 32'd0);
    chk("s4_no_stb", 32'(cnt_stb), 32'd0);
    bus.sd_init_done = 1;
    lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      cyc();
      if (bus.a_gnt) lat = k;
    end
    chk("s4_gnt_within2", 32'(lat >= 1 && lat <= 2), 32'd1);
    bus.a_req = 0;

    // Reset at byte 200 of the A read
    for (int i = 0; i < 200; i++) begin
      bus.sd_sec_read_data_valid = 1; bus.sd_sec_read_data = 8'(i); cyc();
    end
    bus.sd_sec_read_data_valid = 0;
    chk("s5_idx200", 32'(bus.byte_idx), 32'd200);
    rst = 1; bus.sd_init_done = 0; cyc();
    rst = 0;
    chk("s5_strobes", 32'({bus.sd_sec_read, bus.sd_sec_write}), 32'd0);
    chk("s5_no_done", 32'(bus.a_done), 32'd0);
    chk("s5_busy", 32'(bus.busy), 32'd0);
    bus.a_req = 1; bus.a_addr = 32'h99;
    clr_cnt();
    repeat (3) cyc();
    chk("s5_idle_no_gnt", 32'(cnt_gnt), 32'd0);
    bus.sd_init_done = 1;
    wait_gnt("s5_regnt_timeout", who);
    chk("s5_regnt_addr", bus.sd_sec_read_addr, 32'h99);
    bus.a_req = 0;
    pulse_read_end();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
